mc_path_controller: RTL and testbench
=====================================

# mc_path_controller

Sequencer for the Monte Carlo option-pricing datapath. Latches a pricing configuration on `start`, enables the normal-sample generator, waits out the present-value pipeline latency, then accumulates 2^n present-value results, one per cycle. Reports the sum and the mean, and pulses `done`. It sits between the host/FPGA interface registers and the NormalGenerator/PresentValue pair, and supplies their stable configuration inputs.

## Interface
- `PV_LAT`, default 3: fixed latency in cycles from generator enable to the first valid `pv_val`; legal range 1..15.
- `ACC_W`, default 32: accumulator and sum width; must be ≥ 32.
- `clk` in 1: the single clock; every register updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: run request; sampled only in IDLE.
- `abort` in 1: cancels a run in progress.
- `n_log2` in 5: path-count exponent, paths = 2^n_log2; values above 16 are clamped to 16.
- `ker_t`, `se05sigma_t`, `sigma_sqrt_t` in 16 each: unsigned pricing constants.
- `rand_compare` in 16: signed comparison threshold.
- `pv_val` in 16: unsigned present-value result from the datapath.
- `cfg_ker_t`, `cfg_se05sigma_t`, `cfg_sigma_sqrt_t`, `cfg_rand_compare` out 16 each: latched configuration driven to PresentValue.
- `gen_en` out 1: generator/datapath run enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `sum` out ACC_W: accumulated total of the last completed run.
- `mean` out 16: `sum >> n_eff`, truncated.

## Operation
- States:
  - IDLE: `start=1` and `abort=0` → LOAD. Otherwise stay in IDLE.
  - LOAD: one cycle. Latch the four cfg outputs. Set n_eff = min(n_log2,16), latched at the IDLE→LOAD edge. Clear the internal accumulator. → FILL.
  - FILL: exactly PV_LAT cycles, then → ACCUM.
  - ACCUM: exactly 2^n_eff cycles. Each cycle adds zero-extended `pv_val` into the internal accumulator. → DONE.
  - DONE: one cycle. `done=1`. → IDLE.
- `sum` and `mean` load from the internal accumulator at the ACCUM→DONE edge. They hold until the next DONE edge and are unaffected by `start`, LOAD or abort.
- `gen_en` = 1 in LOAD, FILL and ACCUM; 0 in IDLE and DONE.
- Config inputs may change freely while busy; the cfg outputs change only at the IDLE→LOAD edge.
- `start` is ignored while busy; no queuing.
- Abort:
  - `abort=1` in LOAD, FILL or ACCUM → IDLE on the next edge, `done` is not asserted, and `sum`/`mean` are unchanged.
  - `abort=1` in DONE has no effect.
  - `abort=1` together with `start` in IDLE: the start is ignored.
- Width rules: 2^16 × 0xFFFF < 2^32, so the sum cannot overflow at ACC_W=32. `mean` is at most 0xFFFF.

## Timing
- Reset: state IDLE. `gen_en`, `busy`, `done`, `sum`, `mean`, all cfg outputs and the internal counters are 0. Reset overrides everything, including mid-run; no `done` follows a reset.
- If `start` is high in cycle t (IDLE):
  - LOAD at t+1.
  - FILL at t+2 .. t+1+PV_LAT.
  - ACCUM covers the next 2^n cycles.
  - DONE at t+2+PV_LAT+2^n.
- `busy` is high from LOAD through DONE inclusive.
- `sum`/`mean` are valid in the DONE cycle and after it.
- Earliest restart: `start` high in the cycle after DONE.
- Back-to-back runs have one idle cycle: DONE → IDLE, where `start` is sampled.

## Test plan
- Reset: hold `reset` high for 3 cycles mid-ACCUM → next cycle all outputs 0, state IDLE; no `done` in the following 20 cycles.
- Basic run: PV_LAT=3, n_log2=2, `pv_val`=100 constant, `start` at cycle 0 → LOAD at 1, `gen_en` high for cycles 1–8, `done` pulse at cycle 9 only, `sum`=400, `mean`=100, `busy` low at cycle 10.
- Accumulation check: n_log2=0, `pv_val` = 7 only during the single ACCUM cycle (9 elsewhere) → `sum`=7, `mean`=7, DONE at cycle 6.
- Full scale with clamp: n_log2=20, `pv_val`=0xFFFF → 65536 ACCUM cycles, `sum`=0xFFFF0000, `mean`=0xFFFF.
- Abort, then a clean rerun:
  - Run A: n=1, `pv_val`=5 → `sum`=10.
  - Run B: start, abort on its 2nd ACCUM cycle → IDLE next cycle, `gen_en` low, no `done`, `sum` still 10.
  - Run C: n=1, `pv_val`=8 → `sum`=16.
- Busy/config isolation: `start` pulsed during FILL and `ker_t` changed during ACCUM → no second run; `cfg_ker_t` keeps the value latched at LOAD (e.g. 11017); `cfg_rand_compare` = 0xFF88 (−120).

Source files
------------

// File: rtl/mc_path_controller.sv
// Run sequencer for the Monte Carlo pricing datapath.
// Latches config, fills the PV pipeline, then sums 2^n present values.
module mc_path_controller #(
    parameter int PV_LAT = 3,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       n_log2,
    input  logic [15:0]      ker_t,
    input  logic [15:0]      se05sigma_t,
    input  logic [15:0]      sigma_sqrt_t,
    input  logic [15:0]      rand_compare,
    input  logic [15:0]      pv_val,
    output logic [15:0]      cfg_ker_t,
    output logic [15:0]      cfg_se05sigma_t,
    output logic [15:0]      cfg_sigma_sqrt_t,
    output logic [15:0]      cfg_rand_compare,
    output logic             gen_en,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum,
    output logic [15:0]      mean
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam logic [16:0] FILL_LAST = 17'(PV_LAT - 1);

    state_t           state;
    logic [4:0]       n_eff;
    logic [16:0]      cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [16:0]      accum_last;
    logic [4:0]       n_clamp;

    assign acc_next   = acc + ACC_W'(pv_val);
    assign accum_last = (17'd1 << n_eff) - 17'd1;
    assign n_clamp    = (n_log2 > 5'd16) ? 5'd16 : n_log2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            n_eff            <= '0;
            cnt              <= '0;
            acc              <= '0;
            sum              <= '0;
            mean             <= '0;
            gen_en           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_ker_t        <= '0;
            cfg_se05sigma_t  <= '0;
            cfg_sigma_sqrt_t <= '0;
            cfg_rand_compare <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state            <= S_LOAD;
                        cfg_ker_t        <= ker_t;
                        cfg_se05sigma_t  <= se05sigma_t;
                        cfg_sigma_sqrt_t <= sigma_sqrt_t;
                        cfg_rand_compare <= rand_compare;
                        n_eff            <= n_clamp;
                        acc              <= '0;
                        cnt              <= '0;
                        gen_en           <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        state <= S_FILL;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == FILL_LAST) begin
                        state <= S_ACCUM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 17'd1;
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        acc <= acc_next;
                        if (cnt == accum_last) begin
                            // Results capture the final sample too.
                            state  <= S_DONE;
                            sum    <= acc_next;
                            mean   <= 16'(acc_next >> n_eff);
                            done   <= 1'b1;
                            gen_en <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 17'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    gen_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_path_controller.sv
// Directed bench for mc_path_controller.
// Cycle numbers count edges after the cycle in which start is high.
module tb_mc_path_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  n_log2;
    logic [15:0] ker_t;
    logic [15:0] se05sigma_t;
    logic [15:0] sigma_sqrt_t;
    logic [15:0] rand_compare;
    logic [15:0] pv_val;
    logic [15:0] cfg_ker_t;
    logic [15:0] cfg_se05sigma_t;
    logic [15:0] cfg_sigma_sqrt_t;
    logic [15:0] cfg_rand_compare;
    logic        gen_en;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [15:0] mean;

    int n_checks;
    int n_fail;

    mc_path_controller #(.PV_LAT(3), .ACC_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .n_log2           (n_log2),
        .ker_t            (ker_t),
        .se05sigma_t      (se05sigma_t),
        .sigma_sqrt_t     (sigma_sqrt_t),
        .rand_compare     (rand_compare),
        .pv_val           (pv_val),
        .cfg_ker_t        (cfg_ker_t),
        .cfg_se05sigma_t  (cfg_se05sigma_t),
        .cfg_sigma_sqrt_t (cfg_sigma_sqrt_t),
        .cfg_rand_compare (cfg_rand_compare),
        .gen_en           (gen_en),
        .busy             (busy),
        .done             (done),
        .sum              (sum),
        .mean             (mean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a run in the current cycle; returns in cycle 1 (LOAD).
    task automatic kick(input logic [4:0] n);
        n_log2 = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // From cycle 1, advance until done; reports the cycle it was seen.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    logic [10:0] gmask;
    logic [10:0] dmask;
    logic [10:0] bmask;
    logic [31:0] s9;
    logic [15:0] m9;
    int          cyc;
    int          cnt;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        n_log2       = 5'd0;
        ker_t        = 16'd0;
        se05sigma_t  = 16'd0;
        sigma_sqrt_t = 16'd0;
        rand_compare = 16'd0;
        pv_val       = 16'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_gen_en", gen_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cfg_rc", cfg_rand_compare, 0);

        // Basic run: n=2, pv=100
        ker_t        = 16'd11017;
        se05sigma_t  = 16'd300;
        sigma_sqrt_t = 16'd500;
        rand_compare = 16'hFF88;
        pv_val       = 16'd100;
        kick(5'd2);
        gmask = '0;
        dmask = '0;
        bmask = '0;
        s9    = '0;
        m9    = '0;
        for (int c = 1; c <= 10; c++) begin
            gmask[c] = gen_en;
            dmask[c] = done;
            bmask[c] = busy;
            if (c == 9) begin
                s9 = sum;
                m9 = mean;
            end
            if (c < 10) tick();
        end
        check("basic_gen_en_mask", gmask, 11'h1FE);
        check("basic_done_mask", dmask, 11'h200);
        check("basic_busy_mask", bmask, 11'h3FE);
        check("basic_sum", s9, 400);
        check("basic_mean", m9, 100);
        check("basic_cfg_ker", cfg_ker_t, 11017);
        check("basic_cfg_se", cfg_se05sigma_t, 300);
        check("basic_cfg_sig", cfg_sigma_sqrt_t, 500);
        check("basic_cfg_rc", cfg_rand_compare, 16'hFF88);

        // Single-sample run: only the ACCUM cycle sees 7
        pv_val = 16'd9;
        kick(5'd0);
        repeat (4) tick();
        pv_val = 16'd7;
        tick();
        pv_val = 16'd9;
        check("n0_done_c6", done, 1);
        check("n0_sum", sum, 7);
        check("n0_mean", mean, 7);
        tick();

        // Full scale, n clamped to 16
        pv_val = 16'hFFFF;
        kick(5'd20);
        wait_done(70000, cyc);
        check("full_done_cycle", cyc, 65541);
        check("full_sum", sum, 32'hFFFF0000);
        check("full_mean", mean, 16'hFFFF);
        tick();

        // Run A
        pv_val = 16'd5;
        kick(5'd1);
        wait_done(50, cyc);
        check("runA_done_cycle", cyc, 7);
        check("runA_sum", sum, 10);
        tick();

        // Run B: abort on 2nd ACCUM cycle (cycle 6)
        pv_val = 16'd3;
        kick(5'd1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("runB_gen_en", gen_en, 0);
        check("runB_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) cnt++;
            tick();
        end
        check("runB_no_done", cnt, 0);
        check("runB_sum_kept", sum, 10);
        check("runB_mean_kept", mean, 5);

        // Run C
        pv_val = 16'd8;
        kick(5'd1);
        wait_done(50, cyc);
        check("runC_done_cycle", cyc, 7);
        check("runC_sum", sum, 16);
        check("runC_mean", mean, 8);
        tick();

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_gen", gen_en, 0);
        tick();

        // Busy/config isolation
        ker_t        = 16'd11017;
        rand_compare = 16'hFF88;
        pv_val       = 16'd1;
        kick(5'd2);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ker_t = 16'd1234;
        tick();
        tick();
        check("iso_cfg_ker", cfg_ker_t, 11017);
        tick();
        tick();
        check("iso_done_c9", done, 1);
        check("iso_sum", sum, 4);
        tick();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) cnt++;
            tick();
        end
        check("iso_no_rerun", cnt, 0);
        check("iso_cfg_ker_hold", cfg_ker_t, 11017);
        check("iso_cfg_rc", cfg_rand_compare, 16'hFF88);

        // Reset mid-ACCUM
        ker_t  = 16'd555;
        pv_val = 16'd100;
        kick(5'd2);
        repeat (5) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("mid_rst_gen_en", gen_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_mean", mean, 0);
        check("mid_rst_cfg_ker", cfg_ker_t, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("mid_rst_quiet", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
